des_key_schedule: RTL and testbench

- Iterative DES round-key generator; sits directly upstream of the DES round datapath and feeds it one 48-bit subkey per round.
- Applies PC-1 to a 64-bit key once. Then rotates the C/D halves per round and applies PC-2.
- Emits subkeys K1..K16 for encryption or K16..K1 for decryption over a valid/ready handshake.
- A top-level sequencer drives three back-to-back runs for triple-DES.

---
 rtl/des_pkg.sv | 60 ++++++
 rtl/des_pc2.sv | 16 +
 rtl/des_key_schedule.sv | 100 ++++++++++
 tb/tb_des_key_schedule.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants, permutation tables and rotation helpers.
// Shared by the key schedule and the round datapath.
package des_pkg;

  localparam int unsigned DES_ROUNDS   = 16;
  localparam int unsigned DES_KEY_W    = 64;
  localparam int unsigned DES_CD_W     = 28;
  localparam int unsigned DES_SUBKEY_W = 48;

  // Tables hold 1-based DES bit numbers; DES bit 1 is the MSB of the vector.
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount for rounds 1..16 (index 0 = round 1).
  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {StIdle, StRun} ks_state_e;

  function automatic logic [2*DES_CD_W-1:0] pc1(input logic [DES_KEY_W-1:0] key);
    logic [2*DES_CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1[i])];
    end
    return cd;
  endfunction

  function automatic logic [DES_CD_W-1:0] rotl28(input logic [DES_CD_W-1:0] x,
                                                 input logic [1:0] amt);
    return (amt == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [DES_CD_W-1:0] rotr28(input logic [DES_CD_W-1:0] x,
                                                 input logic [1:0] amt);
    return (amt == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit {C, D} to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*DES_CD_W-1:0]   cd_i,
  output logic [DES_SUBKEY_W-1:0] subkey_o
);

  always_comb begin
    subkey_o = '0;
    for (int i = 0; i < 48; i++) begin
      subkey_o[6'(47 - i)] = cd_i[6'(56 - PC2[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator: one 48-bit subkey per valid/ready transfer,
// K1..K16 for encryption or K16..K1 for decryption.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = DES_ROUNDS,
  parameter int unsigned SUBKEY_W   = DES_SUBKEY_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 enc,
  input  logic [DES_KEY_W-1:0] key_in,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [SUBKEY_W-1:0]  subkey,
  output logic [3:0]           round_idx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS - 1);

  ks_state_e             state_q, state_d;
  logic [DES_CD_W-1:0]   c_q, c_d, d_q, d_d;
  logic [3:0]            idx_q, idx_d;
  logic                  enc_q, enc_d;
  logic                  done_q, done_d;
  logic [2*DES_CD_W-1:0] cd0;
  logic [1:0]            shift_amt;

  assign cd0 = pc1(key_in);

  // Encrypt advances to round idx+2; decrypt undoes the shift of round 16-idx.
  assign shift_amt = enc_q ? SHIFTS[idx_q + 4'd1] : SHIFTS[4'd15 - idx_q];

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    enc_d   = enc_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Decrypt starts from C0/D0, which equal C16/D16 after 28 total shifts.
          c_d     = enc ? rotl28(cd0[55:28], 2'd1) : cd0[55:28];
          d_d     = enc ? rotl28(cd0[27:0], 2'd1) : cd0[27:0];
          idx_d   = '0;
          enc_d   = enc;
          state_d = StRun;
        end
      end
      StRun: begin
        if (key_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
            c_d   = enc_q ? rotl28(c_q, shift_amt) : rotr28(c_q, shift_amt);
            d_d   = enc_q ? rotl28(d_q, shift_amt) : rotr28(d_q, shift_amt);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      enc_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (subkey)
  );

  assign key_valid = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign round_idx = idx_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a textbook DES key-schedule model
// that derives each subkey from the raw key using cumulative rotation counts.
module tb_des_key_schedule;

  logic        clk, rst_n, start, enc, key_ready;
  logic [63:0] key_in;
  logic        key_valid, busy, done;
  logic [47:0] subkey;
  logic [3:0]  round_idx;

  int passed, total;

  logic [47:0] got_key [16];
  logic [3:0]  got_idx [16];
  int          got_n, run_cyc;
  logic        run_done;

  localparam logic [63:0] KeyKnown = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1Known  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2Known  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16Known = 48'hCB3D8B0E17F5;

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  des_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .enc       (enc),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .subkey    (subkey),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-r subkey (r = 1..16) straight from the key: rotate C0/D0 by the summed shift count.
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] kout;
    int cum;
    cum = 0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - M_PC1[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int j = 1; j <= r; j++) cum += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
    cum = cum % 28;
    c = (c << cum) | (c >> (28 - cum));
    d = (d << cum) | (d >> (28 - cum));
    cd = {c, d};
    for (int i = 0; i < 48; i++) kout[6'(47 - i)] = cd[6'(56 - M_PC2[i])];
    return kout;
  endfunction

  function automatic logic [47:0] exp_at(input logic [63:0] k, input logic e, input int n);
    return ref_key(k, e ? n + 1 : 16 - n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one schedule with random backpressure, capturing every transferred subkey.
  task automatic do_run(input logic [63:0] k, input logic e, input int stall_pct);
    int cyc;
    got_n = 0;
    key_in = k;
    enc = e;
    start = 1'b1;
    key_ready = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    while (got_n < 16 && cyc < 500) begin
      key_ready = (int'($urandom_range(99)) >= stall_pct);
      if (key_valid && key_ready) begin
        got_key[got_n] = subkey;
        got_idx[got_n] = round_idx;
        got_n++;
      end
      step();
      cyc++;
    end
    key_ready = 1'b0;
    run_cyc = cyc;
    run_done = done;
  endtask

  task automatic test_reset();
    total++;
    if ({key_valid, busy, done, round_idx, subkey} !== 55'd0)
      $display("FAIL reset_outputs got v=%b b=%b d=%b idx=%0d sk=%h required all 0",
               key_valid, busy, done, round_idx, subkey);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
    total++;
    if ({key_valid, busy, done} !== 3'b000)
      $display("FAIL idle_after_reset got v=%b b=%b d=%b required 000", key_valid, busy, done);
    else passed++;
  endtask

  task automatic test_encrypt_known();
    do_run(KeyKnown, 1'b1, 0);
    total++;
    if (got_n !== 16) $display("FAIL enc_count got %0d required 16", got_n);
    else passed++;
    total++;
    if (got_key[0] !== K1Known) $display("FAIL enc_k1 got %h required %h", got_key[0], K1Known);
    else passed++;
    total++;
    if (got_key[1] !== K2Known) $display("FAIL enc_k2 got %h required %h", got_key[1], K2Known);
    else passed++;
    total++;
    if (got_key[15] !== K16Known)
      $display("FAIL enc_k16 got %h required %h", got_key[15], K16Known);
    else passed++;
    for (int n = 0; n < 16; n++) begin
      total++;
      if ({got_idx[n], got_key[n]} !== {4'(n), exp_at(KeyKnown, 1'b1, n)})
        $display("FAIL enc_seq[%0d] got idx=%0d %h required idx=%0d %h", n, got_idx[n],
                 got_key[n], n, exp_at(KeyKnown, 1'b1, n));
      else passed++;
    end
    total++;
    if (run_cyc !== 17 || run_done !== 1'b1)
      $display("FAIL enc_done_latency got cyc=%0d done=%b required cyc=17 done=1",
               run_cyc, run_done);
    else passed++;
    step();
    total++;
    if (done !== 1'b0) $display("FAIL done_pulse_width got done=%b required 0", done);
    else passed++;
  endtask

  task automatic test_decrypt_known();
    do_run(KeyKnown, 1'b0, 0);
    total++;
    if (got_key[0] !== K16Known)
      $display("FAIL dec_first got %h required %h", got_key[0], K16Known);
    else passed++;
    total++;
    if (got_key[14] !== K2Known) $display("FAIL dec_idx14 got %h required %h", got_key[14], K2Known);
    else passed++;
    total++;
    if (got_key[15] !== K1Known) $display("FAIL dec_last got %h required %h", got_key[15], K1Known);
    else passed++;
    for (int n = 0; n < 16; n++) begin
      total++;
      if ({got_idx[n], got_key[n]} !== {4'(n), exp_at(KeyKnown, 1'b0, n)})
        $display("FAIL dec_seq[%0d] got idx=%0d %h required idx=%0d %h", n, got_idx[n],
                 got_key[n], n, exp_at(KeyKnown, 1'b0, n));
      else passed++;
    end
    total++;
    if (run_cyc !== 17 || run_done !== 1'b1)
      $display("FAIL dec_done got cyc=%0d done=%b required cyc=17 done=1", run_cyc, run_done);
    else passed++;
  endtask

  task automatic test_random_keys();
    logic [63:0] k;
    logic e;
    for (int t = 0; t < 6; t++) begin
      k = {$urandom, $urandom};
      e = 1'($urandom_range(1));
      do_run(k, e, 35);
      total++;
      if (got_n !== 16 || run_done !== 1'b1)
        $display("FAIL rand_run%0d got n=%0d done=%b required n=16 done=1", t, got_n, run_done);
      else passed++;
      for (int n = 0; n < 16; n++) begin
        total++;
        if ({got_idx[n], got_key[n]} !== {4'(n), exp_at(k, e, n)})
          $display("FAIL rand%0d_seq[%0d] key=%h enc=%b got idx=%0d %h required idx=%0d %h",
                   t, n, k, e, got_idx[n], got_key[n], n, exp_at(k, e, n));
        else passed++;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int cyc, n, stall;
    logic stalling;
    key_in = KeyKnown;
    enc = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    n = 0;
    stall = 0;
    while (n < 16 && cyc < 100) begin
      stalling = (round_idx == 4'd3) && (stall < 5);
      key_ready = !stalling;
      if (stalling) begin
        stall++;
        total++;
        if ({key_valid, round_idx, subkey} !== {1'b1, 4'd3, ref_key(KeyKnown, 4)})
          $display("FAIL stall_hold%0d got v=%b idx=%0d %h required v=1 idx=3 %h", stall,
                   key_valid, round_idx, subkey, ref_key(KeyKnown, 4));
        else passed++;
      end else if (key_valid) begin
        total++;
        if (subkey !== ref_key(KeyKnown, n + 1))
          $display("FAIL stall_seq[%0d] got %h required %h", n, subkey, ref_key(KeyKnown, n + 1));
        else passed++;
        n++;
      end
      step();
      cyc++;
    end
    key_ready = 1'b0;
    total++;
    if (cyc !== 22 || done !== 1'b1)
      $display("FAIL stall_done got cyc=%0d done=%b required cyc=22 done=1", cyc, done);
    else passed++;
  endtask

  task automatic test_start_ignored();
    logic [63:0] ka, kb;
    int cyc, n;
    ka = {$urandom, $urandom};
    kb = ~ka;
    key_in = ka;
    enc = 1'b1;
    start = 1'b1;
    key_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    n = 0;
    while (n < 16 && cyc < 100) begin
      start = (round_idx == 4'd7);
      key_in = start ? kb : ka;
      enc = !start;
      if (key_valid) begin
        total++;
        if (subkey !== ref_key(ka, n + 1))
          $display("FAIL ign_seq[%0d] got %h required %h", n, subkey, ref_key(ka, n + 1));
        else passed++;
        n++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    enc = 1'b1;
    total++;
    if (done !== 1'b1 || cyc !== 17)
      $display("FAIL ign_done got done=%b cyc=%0d required done=1 cyc=17", done, cyc);
    else passed++;
    // Start in the done cycle must be accepted.
    key_in = kb;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({key_valid, busy, round_idx, subkey} !== {2'b11, 4'd0, ref_key(kb, 1)})
      $display("FAIL b2b_first got v=%b b=%b idx=%0d %h required v=1 b=1 idx=0 %h", key_valid,
               busy, round_idx, subkey, ref_key(kb, 1));
    else passed++;
    for (int i = 0; i < 40 && !done; i++) step();
    key_ready = 1'b0;
    total++;
    if (done !== 1'b1) $display("FAIL b2b_done got done=%b required 1", done);
    else passed++;
    step();
  endtask

  task automatic test_async_reset();
    logic [63:0] k;
    k = {$urandom, $urandom};
    key_in = k;
    enc = 1'b1;
    start = 1'b1;
    key_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && round_idx != 4'd9; i++) step();
    total++;
    if (round_idx !== 4'd9) $display("FAIL rst_reach_idx9 got %0d required 9", round_idx);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({key_valid, busy, done, round_idx, subkey} !== 55'd0)
      $display("FAIL async_rst got v=%b b=%b d=%b idx=%0d sk=%h required all 0",
               key_valid, busy, done, round_idx, subkey);
    else passed++;
    key_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    key_in = k;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({key_valid, round_idx, subkey} !== {1'b1, 4'd0, ref_key(k, 1)})
      $display("FAIL post_rst_first got v=%b idx=%0d %h required v=1 idx=0 %h",
               key_valid, round_idx, subkey, ref_key(k, 1));
    else passed++;
    key_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) step();
    key_ready = 1'b0;
    total++;
    if (done !== 1'b1) $display("FAIL post_rst_done got done=%b required 1", done);
    else passed++;
    step();
  endtask

  task automatic test_weak_key();
    do_run(64'h0101010101010101, 1'b1, 0);
    for (int n = 0; n < 16; n++) begin
      total++;
      if (got_key[n] !== 48'h0) $display("FAIL weak_seq[%0d] got %h required 0", n, got_key[n]);
      else passed++;
    end
    step();
    do_run(64'h0, 1'b1, 20);
    total++;
    if (got_n !== 16) $display("FAIL zero_count got %0d required 16", got_n);
    else passed++;
    for (int n = 0; n < 16; n++) begin
      total++;
      if (got_key[n] !== 48'h0) $display("FAIL zero_seq[%0d] got %h required 0", n, got_key[n]);
      else passed++;
    end
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total = 0;
    rst_n = 1'b0;
    start = 1'b0;
    enc = 1'b0;
    key_in = '0;
    key_ready = 1'b0;
    #12;
    test_reset();
    test_encrypt_known();
    test_decrypt_known();
    test_backpressure();
    test_start_ignored();
    test_random_keys();
    test_async_reset();
    test_weak_key();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
